// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: compares the predicted and actual direction, issues a registered
// redirect with a recovered GHR, and queues each outcome for the gshare PHT update port.
module branch_resolve_unit #(
  parameter int GHR_WIDTH  = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 branchE,
  input  logic                 pred_takeE,
  input  logic                 actual_takeE,
  input  logic                 stallE,
  input  logic                 flushE,
  input  logic [31:0]          pcE,
  input  logic [31:0]          targetE,
  output logic                 stall_req,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [GHR_WIDTH-1:0] ghr_recover,
  output logic                 upd_valid,
  input  logic                 upd_ready,
  output logic [31:0]          upd_pc,
  output logic [GHR_WIDTH-1:0] upd_ghr,
  output logic                 upd_taken,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mp_count,
  output logic                 overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic [31:0]           r_memPc    [FIFO_DEPTH];
  logic [GHR_WIDTH-1:0]  r_memGhr   [FIFO_DEPTH];
  logic                  r_memTaken [FIFO_DEPTH];
  logic [GHR_WIDTH-1:0]  r_ghr;
  logic [GHR_WIDTH-1:0]  r_ghrRecover;
  logic                  r_redirectValid;
  logic [31:0]           r_redirectPc;
  logic [CNT_WIDTH-1:0]  r_brCount;
  logic [CNT_WIDTH-1:0]  r_mpCount;
  logic                  r_overflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_res;
  logic                  w_mp;
  logic                  w_pop;
  logic                  w_push;
  logic [GHR_WIDTH-1:0]  w_ghrNext;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign stall_req = w_full & branchE & ~upd_ready;

  // stall_req reaches us back as stallE; if the hazard unit ignores it the branch still
  // resolves and the queue entry is dropped (recorded in overflow).
  assign w_res     = branchE & ~stallE & ~flushE;
  assign w_mp      = w_res & (pred_takeE != actual_takeE);
  assign w_pop     = ~w_empty & upd_ready;
  assign w_push    = w_res & (~w_full | w_pop);
  assign w_ghrNext = {r_ghr[GHR_WIDTH-2:0], actual_takeE};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_memPc[i]    <= '0;
        r_memGhr[i]   <= '0;
        r_memTaken[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_memPc[r_wptr[AW-1:0]]    <= pcE;
        r_memGhr[r_wptr[AW-1:0]]   <= r_ghr;
        r_memTaken[r_wptr[AW-1:0]] <= actual_takeE;
        r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr           <= '0;
      r_ghrRecover    <= '0;
      r_redirectValid <= 1'b0;
      r_redirectPc    <= '0;
      r_overflow      <= 1'b0;
    end else begin
      r_redirectValid <= w_mp;
      if (w_res) begin
        r_ghr <= w_ghrNext;
      end
      if (w_mp) begin
        r_ghrRecover <= w_ghrNext;
        r_redirectPc <= actual_takeE ? targetE : (pcE + 32'd8);
      end
      if (w_res && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brCount <= '0;
      r_mpCount <= '0;
    end else begin
      if (w_res && (r_brCount != {CNT_WIDTH{1'b1}})) begin
        r_brCount <= r_brCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_mp && (r_mpCount != {CNT_WIDTH{1'b1}})) begin
        r_mpCount <= r_mpCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign redirect_valid = r_redirectValid;
  assign redirect_pc    = r_redirectPc;
  assign ghr_recover    = r_ghrRecover;
  assign upd_valid      = ~w_empty;
  assign upd_pc         = r_memPc[r_rptr[AW-1:0]];
  assign upd_ghr        = r_memGhr[r_rptr[AW-1:0]];
  assign upd_taken      = r_memTaken[r_rptr[AW-1:0]];
  assign br_count       = r_brCount;
  assign mp_count       = r_mpCount;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized traffic,
// compared against a queue-based reference model; a CNT_WIDTH=4 copy exercises saturation.
module tb_branch_resolve_unit;

  localparam int GW    = 20;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, branchE, pred_takeE, actual_takeE, stallE, flushE, upd_ready;
  logic [31:0] pcE, targetE;

  logic          stall_req, redirect_valid, upd_valid, upd_taken, overflow;
  logic [31:0]   redirect_pc, upd_pc, br_count, mp_count;
  logic [GW-1:0] ghr_recover, upd_ghr;

  logic          stall_req4, redirect_valid4, upd_valid4, upd_taken4, overflow4;
  logic [31:0]   redirect_pc4, upd_pc4;
  logic [3:0]    br_count4, mp_count4;
  logic [GW-1:0] ghr_recover4, upd_ghr4;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .branchE(branchE), .pred_takeE(pred_takeE),
    .actual_takeE(actual_takeE), .stallE(stallE), .flushE(flushE), .pcE(pcE),
    .targetE(targetE), .stall_req(stall_req), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ghr_recover(ghr_recover), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .br_count(br_count), .mp_count(mp_count), .overflow(overflow)
  );

  branch_resolve_unit #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .branchE(branchE), .pred_takeE(pred_takeE),
    .actual_takeE(actual_takeE), .stallE(stallE), .flushE(flushE), .pcE(pcE),
    .targetE(targetE), .stall_req(stall_req4), .redirect_valid(redirect_valid4),
    .redirect_pc(redirect_pc4), .ghr_recover(ghr_recover4), .upd_valid(upd_valid4),
    .upd_ready(upd_ready), .upd_pc(upd_pc4), .upd_ghr(upd_ghr4), .upd_taken(upd_taken4),
    .br_count(br_count4), .mp_count(mp_count4), .overflow(overflow4)
  );

  typedef struct {
    logic [31:0]   pc;
    logic [GW-1:0] ghr;
    logic          taken;
  } entry_t;

  entry_t        mq[$];
  logic [GW-1:0] mGhr, mRecover;
  logic          mRv, mOvf;
  logic [31:0]   mRpc;
  longint        mBr, mMp, mBr4, mMp4;
  int            nChecks = 0;
  int            nFails  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mGhr = '0; mRecover = '0; mRv = 1'b0; mRpc = '0; mOvf = 1'b0;
    mBr = 0; mMp = 0; mBr4 = 0; mMp4 = 0;
  endtask

  // Reference behaviour for one clock edge, using the inputs currently applied.
  task automatic modelStep();
    bit     res, mp;
    entry_t e;
    res = branchE && !stallE && !flushE;
    mp  = res && (pred_takeE != actual_takeE);
    if (mq.size() > 0 && upd_ready) void'(mq.pop_front());
    mRv = mp;
    if (res) begin
      if (mq.size() < DEPTH) begin
        e.pc = pcE; e.ghr = mGhr; e.taken = actual_takeE;
        mq.push_back(e);
      end else begin
        mOvf = 1'b1;
      end
      mGhr = GW'((longint'(mGhr) * 2) + longint'(actual_takeE));
      if (mBr  < 64'hFFFF_FFFF) mBr++;
      if (mBr4 < 15) mBr4++;
    end
    if (mp) begin
      mRecover = mGhr;
      mRpc     = actual_takeE ? targetE : pcE + 32'd8;
      if (mMp  < 64'hFFFF_FFFF) mMp++;
      if (mMp4 < 15) mMp4++;
    end
  endtask

  task automatic checkComb();
    bit expStall;
    expStall = (mq.size() == DEPTH) && branchE && !upd_ready;
    checkOutput("stall_req",  64'(stall_req),  64'(expStall));
    checkOutput("stall_req4", 64'(stall_req4), 64'(expStall));
    checkOutput("upd_valid",  64'(upd_valid),  64'(mq.size() != 0));
    checkOutput("upd_valid4", 64'(upd_valid4), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkOutput("upd_pc",     64'(upd_pc),     64'(mq[0].pc));
      checkOutput("upd_ghr",    64'(upd_ghr),    64'(mq[0].ghr));
      checkOutput("upd_taken",  64'(upd_taken),  64'(mq[0].taken));
      checkOutput("upd_pc4",    64'(upd_pc4),    64'(mq[0].pc));
      checkOutput("upd_ghr4",   64'(upd_ghr4),   64'(mq[0].ghr));
      checkOutput("upd_taken4", 64'(upd_taken4), 64'(mq[0].taken));
    end
  endtask

  task automatic checkRegs();
    checkOutput("redirect_valid",  64'(redirect_valid),  64'(mRv));
    checkOutput("redirect_pc",     64'(redirect_pc),     64'(mRpc));
    checkOutput("ghr_recover",     64'(ghr_recover),     64'(mRecover));
    checkOutput("overflow",        64'(overflow),        64'(mOvf));
    checkOutput("br_count",        64'(br_count),        64'(mBr));
    checkOutput("mp_count",        64'(mp_count),        64'(mMp));
    checkOutput("redirect_valid4", 64'(redirect_valid4), 64'(mRv));
    checkOutput("redirect_pc4",    64'(redirect_pc4),    64'(mRpc));
    checkOutput("ghr_recover4",    64'(ghr_recover4),    64'(mRecover));
    checkOutput("overflow4",       64'(overflow4),       64'(mOvf));
    checkOutput("br_count4",       64'(br_count4),       64'(mBr4));
    checkOutput("mp_count4",       64'(mp_count4),       64'(mMp4));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " stall_req"},      64'(stall_req),      64'd0);
    checkOutput({tag, " redirect_valid"}, 64'(redirect_valid), 64'd0);
    checkOutput({tag, " redirect_pc"},    64'(redirect_pc),    64'd0);
    checkOutput({tag, " ghr_recover"},    64'(ghr_recover),    64'd0);
    checkOutput({tag, " upd_valid"},      64'(upd_valid),      64'd0);
    checkOutput({tag, " upd_pc"},         64'(upd_pc),         64'd0);
    checkOutput({tag, " upd_ghr"},        64'(upd_ghr),        64'd0);
    checkOutput({tag, " upd_taken"},      64'(upd_taken),      64'd0);
    checkOutput({tag, " br_count"},       64'(br_count),       64'd0);
    checkOutput({tag, " mp_count"},       64'(mp_count),       64'd0);
    checkOutput({tag, " overflow"},       64'(overflow),       64'd0);
    checkOutput({tag, " upd_valid4"},     64'(upd_valid4),     64'd0);
    checkOutput({tag, " br_count4"},      64'(br_count4),      64'd0);
    checkOutput({tag, " mp_count4"},      64'(mp_count4),      64'd0);
  endtask

  task automatic applyStimulus(input logic b, input logic p, input logic a, input logic s,
                               input logic f, input logic [31:0] pc, input logic [31:0] tgt,
                               input logic rdy);
    @(negedge clk);
    branchE = b; pred_takeE = p; actual_takeE = a; stallE = s; flushE = f;
    pcE = pc; targetE = tgt; upd_ready = rdy;
    #1;
    checkComb();
    @(posedge clk);
    modelStep();
    #1;
    checkRegs();
  endtask

  // Asserts reset a few ns after a rising edge so the outputs must clear without a clock.
  task automatic resetMidCycle(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero(tag);
    modelReset();
    branchE = 1'b0; upd_ready = 1'b0; stallE = 1'b0; flushE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic b, p, a, s, f, r;
    rst_n = 1'b0; branchE = 1'b0; pred_takeE = 1'b0; actual_takeE = 1'b0;
    stallE = 1'b0; flushE = 1'b0; upd_ready = 1'b0; pcE = '0; targetE = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("init");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] correct prediction then mispredict");
    applyStimulus(1, 1, 1, 0, 0, 32'h0000_0100, 32'h0000_0200, 0);
    applyStimulus(1, 1, 0, 0, 0, 32'hBFC0_0010, 32'h1234_5678, 0);
    checkOutput("mp redirect_pc const", 64'(redirect_pc), 64'hBFC0_0018);
    checkOutput("mp count const",       64'(mp_count),    64'd1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("redirect one cycle",   64'(redirect_valid), 64'd0);

    $display("[TB] fill queue and force overflow");
    applyStimulus(1, 0, 1, 0, 0, 32'h0000_0300, 32'h0000_0400, 0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0000_0500, 32'h0000_0600, 0);
    applyStimulus(1, 1, 1, 0, 0, 32'h0000_0700, 32'h0000_0800, 0);
    checkOutput("overflow const", 64'(overflow), 64'd1);

    $display("[TB] push and pop on full queue, then drain");
    applyStimulus(1, 0, 0, 0, 0, 32'h0000_0900, 32'h0000_0A00, 1);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 1);

    $display("[TB] counter saturation and reset mid-drain");
    for (int i = 0; i < 20; i++) begin
      a = 1'($urandom);
      applyStimulus(1, ~a, a, 0, 0, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 1);
    end
    checkOutput("br_count4 saturated", 64'(br_count4), 64'd15);
    checkOutput("mp_count4 saturated", 64'(mp_count4), 64'd15);
    repeat (3) applyStimulus(1, 1, 1, 0, 0, $urandom & 32'hFFFF_FFFC, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    resetMidCycle("mid-drain");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      b = ($urandom % 10) < 7;
      p = 1'($urandom);
      a = 1'($urandom);
      f = ($urandom % 10) == 0;
      r = 1'($urandom);
      if (mq.size() == DEPTH && b && !r) s = ($urandom % 16) != 0;
      else                              s = ($urandom % 10) == 0;
      applyStimulus(b, p, a, s, f, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, r);
      if (i == 200) resetMidCycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
